// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - dual-ported in-order instruction issue queue
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int SET_W = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       stall,
  input  logic                       in_valid1,
  input  logic                       in_valid2,
  input  logic [SET_W-1:0]           in_set1,
  input  logic [SET_W-1:0]           in_set2,
  input  logic [4:0]                 in_rd1,
  input  logic [4:0]                 in_rd2,
  input  logic                       in_we1,
  input  logic                       in_we2,
  input  logic [4:0]                 in_rs1_1,
  input  logic [4:0]                 in_rs2_1,
  input  logic [4:0]                 in_rs1_2,
  input  logic [4:0]                 in_rs2_2,
  input  logic                       in_mem1,
  input  logic                       in_mem2,
  output logic                       in_ready,
  output logic                       o_valid1,
  output logic                       o_valid2,
  output logic [SET_W-1:0]           o_set1,
  output logic [SET_W-1:0]           o_set2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  // Entry storage; contents are don't-care until written, so it is not reset.
  logic [SET_W-1:0] set_q [DEPTH];
  logic [4:0]       rd_q  [DEPTH];
  logic [4:0]       rs1_q [DEPTH];
  logic [4:0]       rs2_q [DEPTH];
  logic [DEPTH-1:0] we_q;
  logic [DEPTH-1:0] mem_q;

  logic [AW-1:0] head, tail;
  logic [AW-1:0] head1, tail1;
  logic          enq;
  logic [1:0]    enq_n, deq_n;
  logic          hazard;
  logic          raw_hz, waw_hz, mem_hz;

  // Pointers are AW bits wide, so +1 wraps modulo DEPTH for free.
  assign head1 = head + AW'(1);
  assign tail1 = tail + AW'(1);

  // Room for a full decoder pair, judged from the registered count only.
  assign in_ready = (count <= (AW+1)'(DEPTH - 2));
  assign enq      = in_ready & in_valid1 & ~flush;
  assign enq_n    = enq ? (in_valid2 ? 2'd2 : 2'd1) : 2'd0;

  // Pairing hazards between head (older) and head+1 (younger).
  assign raw_hz = we_q[head] && (rd_q[head] != 5'd0) &&
                  ((rd_q[head] == rs1_q[head1]) || (rd_q[head] == rs2_q[head1]));
  assign waw_hz = we_q[head] && we_q[head1] && (rd_q[head] == rd_q[head1]) &&
                  (rd_q[head] != 5'd0);
  assign mem_hz = mem_q[head] && mem_q[head1];
  assign hazard = raw_hz | waw_hz | mem_hz;

  assign o_valid1 = (count != '0) & ~stall & ~flush;
  assign o_valid2 = (count > (AW+1)'(1)) & ~hazard & ~stall & ~flush;
  assign deq_n    = {1'b0, o_valid1} + {1'b0, o_valid2};

  assign o_set1 = set_q[head];
  assign o_set2 = set_q[head1];

  // Write accepted decoder slots at tail and tail+1.
  always_ff @(posedge clk) begin
    if (enq) begin
      set_q[tail] <= in_set1;
      rd_q[tail]  <= in_rd1;
      rs1_q[tail] <= in_rs1_1;
      rs2_q[tail] <= in_rs2_1;
      we_q[tail]  <= in_we1;
      mem_q[tail] <= in_mem1;
      if (in_valid2) begin
        set_q[tail1] <= in_set2;
        rd_q[tail1]  <= in_rd2;
        rs1_q[tail1] <= in_rs1_2;
        rs2_q[tail1] <= in_rs2_2;
        we_q[tail1]  <= in_we2;
        mem_q[tail1] <= in_mem2;
      end
    end
  end

  // Advance pointers and occupancy; flush empties the queue outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(deq_n);
      tail  <= tail + AW'(enq_n);
      count <= count + (AW+1)'(enq_n) - (AW+1)'(deq_n);
    end
  end

endmodule
